// File: rtl/drum_spi_event_queue.sv
// drum_spi_event_queue: FIFO of drum trigger events serialised to the MCU as SPI mode-0 frames.
// Define DRUM_SPI_TIMESTAMP_EN to capture a 16-bit timestamp per event and extend frames to 32 bits.
module drum_spi_event_queue #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CODE_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sck,
    input  logic                        sdi,
    output logic                        sdo,
    input  logic                        load,
    output logic                        done,
    input  logic                        drum_trigger_valid,
    input  logic [CODE_W-1:0]           drum_code,
    input  logic [7:0]                  drum_velocity,
    output logic                        command_sent,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef DRUM_SPI_TIMESTAMP_EN
    localparam int FRAME_BITS = 32;
    localparam int ENTRY_W    = CODE_W + 24;
    logic [15:0] ts;
    logic [ENTRY_W-1:0] push_entry;
    always_ff @(posedge clk) ts <= reset ? 16'd0 : ts + 16'd1;
    assign push_entry = {drum_code, drum_velocity, ts};
`else
    localparam int FRAME_BITS = 16;
    localparam int ENTRY_W    = CODE_W + 8;
    logic [ENTRY_W-1:0] push_entry;
    assign push_entry = {drum_code, drum_velocity};
`endif
    localparam int BW = $clog2(FRAME_BITS) + 1;

    typedef enum logic [1:0] {EMPTY, PRELOAD, READY, POP} state_t;
    state_t state;

    logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [BW-1:0]         bitcnt;
    logic                  ovf_pending;
    logic [SYNC_STAGES-1:0] sck_s, load_s;
    logic                  sck_d, load_d;
    logic                  unused_sdi;

    assign unused_sdi = sdi;

    logic sck_fall, load_rise, pop, full, push_ok, drop;
    logic [CW-1:0] count_nxt;
    logic [ENTRY_W-1:0] head;
    logic [FRAME_BITS-1:0] frame;

    assign sck_fall  = sck_d & ~sck_s[SYNC_STAGES-1];
    assign load_rise = load_s[SYNC_STAGES-1] & ~load_d;
    assign pop       = state == POP;
    assign full      = fifo_count == CW'(FIFO_DEPTH);
    assign push_ok   = drum_trigger_valid & (~full | pop);
    assign drop      = drum_trigger_valid & full & ~pop;
    assign count_nxt = fifo_count + CW'(push_ok) - CW'(pop);
    assign head      = mem[rd_ptr];
    // Code is zero-extended to 7 bits so the pending-drop flag lands in the frame MSB.
    assign frame     = {ovf_pending, 7'(head[ENTRY_W-1 -: CODE_W]), head[ENTRY_W-CODE_W-1:0]};
    assign sdo       = (state == READY) & shift_reg[FRAME_BITS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s  <= '0;
            load_s <= '0;
            sck_d  <= 1'b0;
            load_d <= 1'b0;
        end else begin
            sck_s  <= {sck_s[SYNC_STAGES-2:0], sck};
            load_s <= {load_s[SYNC_STAGES-2:0], load};
            sck_d  <= sck_s[SYNC_STAGES-1];
            load_d <= load_s[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= EMPTY;
            done         <= 1'b0;
            command_sent <= 1'b0;
            fifo_count   <= '0;
            overflow     <= 1'b0;
            ovf_pending  <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            shift_reg    <= '0;
            bitcnt       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            fifo_count   <= count_nxt;
            command_sent <= 1'b0;
            ovf_pending  <= drop | (ovf_pending & (state != PRELOAD));
            if (drop) overflow <= 1'b1;
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            case (state)
                EMPTY: if (fifo_count != '0) state <= PRELOAD;
                PRELOAD: begin
                    shift_reg <= frame;
                    bitcnt    <= '0;
                    done      <= 1'b1;
                    state     <= READY;
                end
                READY: begin
                    if (load_rise) begin
                        done  <= 1'b0;
                        state <= POP;
                    end else if (sck_fall && bitcnt < BW'(FRAME_BITS)) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                        bitcnt    <= bitcnt + BW'(1);
                    end
                end
                POP: begin
                    rd_ptr       <= rd_ptr + AW'(1);
                    command_sent <= 1'b1;
                    state        <= (count_nxt != '0) ? PRELOAD : EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
